// File: rtl/uart_rx_timeout_mc.sv
// Multi-channel UART receive timeout: per-channel character-time watchdog that
// raises an interrupt when the RX FIFO holds data but sees no traffic.
module uart_rx_timeout_mc #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 12,
  parameter int unsigned TO_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      div_clk_en,
  input  logic [N_CH-1:0]      rx_valid,
  input  logic [N_CH-1:0]      rhr_valid,
  input  logic [N_CH-1:0]      rd_rhr,
  input  logic [N_CH-1:0]      int_clr,
  input  logic [2*N_CH-1:0]    cfg_word_len,
  input  logic [N_CH-1:0]      cfg_stop_bit,
  input  logic [N_CH-1:0]      cfg_parity_en,
  input  logic [N_CH-1:0]      cfg_fifo_enable,
  input  logic [TO_W*N_CH-1:0] cfg_to_chars,
  output logic [N_CH-1:0]      int_rx_timeout,
  output logic                 int_any
);

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRED, ACKED} state_e;

  logic [N_CH-1:0] int_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load;
    logic [3:0]       frame_len;
    logic [TO_W-1:0]  to_chars;
    logic             armed;
    logic             kick;

    // Reload value in 16x ticks: chars * (start + data + parity + stop bits) * 16
    always_comb begin
      to_chars  = cfg_to_chars[TO_W*i +: TO_W];
      frame_len = 4'd7 + {2'b00, cfg_word_len[2*i +: 2]}
                + {3'b000, cfg_stop_bit[i]} + {3'b000, cfg_parity_en[i]};
      load      = CNT_W'(to_chars) * CNT_W'({frame_len, 4'b0000});
    end

    assign armed = cfg_fifo_enable[i] & rhr_valid[i] & (to_chars != '0);
    assign kick  = rx_valid[i] | rd_rhr[i];

    // Next-state: disarming overrides everything; traffic reload beats decrement
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!armed) begin
        state_d = IDLE;
        cnt_d   = load;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = COUNT;
            cnt_d   = load;
          end
          COUNT: begin
            if (kick) begin
              cnt_d = load;
            end else if (div_clk_en[i]) begin
              if (cnt_q > CNT_W'(1)) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                state_d = EXPIRED;
                cnt_d   = '0;
              end
            end
          end
          EXPIRED: begin
            if (kick) begin
              state_d = COUNT;
              cnt_d   = load;
            end else if (int_clr[i]) begin
              state_d = ACKED;
            end
          end
          ACKED: begin
            if (kick) begin
              state_d = COUNT;
              cnt_d   = load;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = load;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign int_d[i] = (state_d == EXPIRED);
  end

  // Interrupt outputs track the next state so they switch on the entering edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_rx_timeout <= '0;
      int_any        <= 1'b0;
    end else begin
      int_rx_timeout <= int_d;
      int_any        <= |int_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_timeout_mc.sv
// Self-checking bench for uart_rx_timeout_mc: table of frame configurations plus
// hand-written sequences for reload, acknowledge, disarm and reset corners.
module tb_uart_rx_timeout_mc;

  logic        clk;
  logic        rst;
  logic [3:0]  div_clk_en, rx_valid, rhr_valid, rd_rhr, int_clr;
  logic [7:0]  cfg_word_len;
  logic [3:0]  cfg_stop_bit, cfg_parity_en, cfg_fifo_enable;
  logic [11:0] cfg_to_chars;
  logic [3:0]  int_rx_timeout;
  logic        int_any;

  uart_rx_timeout_mc #(.N_CH(4), .CNT_W(12), .TO_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_clk_en     (div_clk_en),
    .rx_valid       (rx_valid),
    .rhr_valid      (rhr_valid),
    .rd_rhr         (rd_rhr),
    .int_clr        (int_clr),
    .cfg_word_len   (cfg_word_len),
    .cfg_stop_bit   (cfg_stop_bit),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_fifo_enable(cfg_fifo_enable),
    .cfg_to_chars   (cfg_to_chars),
    .int_rx_timeout (int_rx_timeout),
    .int_any        (int_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] exp_int;
    logic       exp_any;
  } sb_t;

  typedef struct {
    logic [1:0] wl;
    logic       stop;
    logic       par;
    logic [2:0] to;
    int         load;
  } vec_t;

  sb_t   sb_q[$];
  vec_t  vt[6];
  int    n_vec;
  int    n_bad;
  string phase;
  logic [3:0] exp_int;

  // One clock: expectation queued with the stimulus, checked on the falling edge
  task automatic step();
    sb_t e;
    e.exp_int = exp_int;
    e.exp_any = |exp_int;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    n_vec++;
    if (int_rx_timeout !== e.exp_int || int_any !== e.exp_any) begin
      n_bad++;
      $display("FAIL %s: int_rx_timeout=%b int_any=%b, expected %b %b",
               phase, int_rx_timeout, int_any, e.exp_int, e.exp_any);
    end
    div_clk_en = '0;
    rx_valid   = '0;
    rd_rhr     = '0;
    int_clr    = '0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      div_clk_en = '1;
      step();
      step();
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] wl, input logic st,
                        input logic pa, input logic [2:0] to, input logic fe);
    cfg_word_len[2*ch +: 2]  = wl;
    cfg_stop_bit[ch]         = st;
    cfg_parity_en[ch]        = pa;
    cfg_to_chars[3*ch +: 3]  = to;
    cfg_fifo_enable[ch]      = fe;
  endtask

  task automatic do_reset();
    div_clk_en = '0; rx_valid = '0; rhr_valid = '0; rd_rhr = '0; int_clr = '0;
    cfg_word_len = '0; cfg_stop_bit = '0; cfg_parity_en = '0;
    cfg_fifo_enable = '0; cfg_to_chars = '0;
    exp_int = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    n_vec = 0;
    n_bad = 0;
    // frame length = 2 + data + stop + parity; load = chars * frame * 16
    vt[0] = '{2'd3, 1'b0, 1'b0, 3'd4, 640};
    vt[1] = '{2'd0, 1'b1, 1'b1, 3'd7, 1008};
    vt[2] = '{2'd0, 1'b0, 1'b0, 3'd1, 112};
    vt[3] = '{2'd3, 1'b1, 1'b1, 3'd7, 1344};
    vt[4] = '{2'd2, 1'b1, 1'b0, 3'd2, 320};
    vt[5] = '{2'd1, 1'b0, 1'b1, 3'd3, 432};

    phase = "reset";
    do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Table: one channel live; siblings carry traffic but are disabled
    for (int v = 0; v < 6; v++) begin
      c = v % 4;
      phase = $sformatf("vec%0d", v);
      do_reset();
      for (int k = 0; k < 4; k++) begin
        if (k % 2 == 1) set_ch(k, 2'd3, 1'b0, 1'b0, 3'd0, 1'b1);
        else            set_ch(k, 2'd3, 1'b0, 1'b0, 3'd4, 1'b0);
      end
      set_ch(c, vt[v].wl, vt[v].stop, vt[v].par, vt[v].to, 1'b1);
      rhr_valid = '1;
      rx_valid  = '1;
      phase = $sformatf("vec%0d_arm", v);
      step();
      phase = $sformatf("vec%0d_count", v);
      pulses(vt[v].load - 1);
      exp_int[c] = 1'b1;
      phase = $sformatf("vec%0d_expire", v);
      pulses(1);
      int_clr = '1;
      exp_int = '0;
      phase = $sformatf("vec%0d_ack", v);
      step();
      pulses(50);
      rhr_valid = '0;
      step();
    end

    // Ch1: host read one pulse short of expiry restarts the full count
    phase = "ch1_rdrhr";
    do_reset();
    set_ch(1, 2'd0, 1'b1, 1'b1, 3'd7, 1'b1);
    rhr_valid = 4'b0010;
    rx_valid[1] = 1'b1;
    step();
    pulses(999);
    div_clk_en = '1;
    rd_rhr[1]  = 1'b1;
    step();
    step();
    pulses(1007);
    exp_int[1] = 1'b1;
    phase = "ch1_expire";
    pulses(1);

    // Ch2: config change mid-count, then disarm via rhr_valid and re-arm
    phase = "ch2_count";
    do_reset();
    set_ch(2, 2'd3, 1'b0, 1'b0, 3'd1, 1'b1);
    rhr_valid = 4'b0100;
    rx_valid[2] = 1'b1;
    step();
    pulses(50);
    cfg_to_chars[8:6] = 3'd7;
    pulses(109);
    exp_int[2] = 1'b1;
    phase = "ch2_expire";
    pulses(1);
    rhr_valid[2] = 1'b0;
    exp_int = '0;
    phase = "ch2_idle";
    step();
    pulses(200);
    rhr_valid[2] = 1'b1;
    rx_valid[2]  = 1'b1;
    phase = "ch2_recount";
    step();
    pulses(1119);
    exp_int[2] = 1'b1;
    phase = "ch2_reexpire";
    pulses(1);

    // Ch3: int_clr during count ignored; ack holds low until new traffic
    phase = "ch3_count";
    do_reset();
    set_ch(3, 2'd3, 1'b0, 1'b0, 3'd2, 1'b1);
    rhr_valid = 4'b1000;
    rx_valid[3] = 1'b1;
    step();
    pulses(100);
    int_clr[3] = 1'b1;
    step();
    pulses(219);
    exp_int[3] = 1'b1;
    phase = "ch3_expire";
    pulses(1);
    int_clr[3] = 1'b1;
    exp_int = '0;
    phase = "ch3_acked";
    step();
    pulses(400);
    rx_valid[3] = 1'b1;
    phase = "ch3_recount";
    step();
    pulses(319);
    exp_int[3] = 1'b1;
    phase = "ch3_reexpire";
    pulses(1);

    // Ch0: traffic on the final tick, kick out of EXPIRED, async reset
    phase = "ch0_count";
    do_reset();
    set_ch(0, 2'd3, 1'b0, 1'b0, 3'd1, 1'b1);
    rhr_valid = 4'b0001;
    rx_valid[0] = 1'b1;
    step();
    pulses(159);
    div_clk_en  = '1;
    rx_valid[0] = 1'b1;
    phase = "ch0_final_tick_rx";
    step();
    step();
    pulses(159);
    exp_int[0] = 1'b1;
    phase = "ch0_expire";
    pulses(1);
    rd_rhr[0] = 1'b1;
    exp_int = '0;
    phase = "ch0_kick";
    step();
    pulses(159);
    exp_int[0] = 1'b1;
    phase = "ch0_reexpire";
    pulses(1);
    rst = 1'b1;
    #1;
    n_vec++;
    if (int_rx_timeout !== 4'b0000 || int_any !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: int_rx_timeout=%b int_any=%b, expected 0000 0",
               int_rx_timeout, int_any);
    end
    exp_int = '0;
    phase = "ch0_in_rst";
    step();
    rst = 1'b0;
    phase = "ch0_post_rst";
    step();
    pulses(159);
    exp_int[0] = 1'b1;
    phase = "ch0_post_rst_expire";
    pulses(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_timeout_mc.md
UART_RX_TIMEOUT_MC -- requirements
Module: uart_rx_timeout_mc

Interface
REQ-001: Parameter N_CH, default 4, number of independent UART receive channels (1..16).
REQ-002: Parameter CNT_W, default 12, timeout counter width per channel; SHALL be at least 11.
REQ-003: Parameter TO_W, default 3, width of per-channel timeout-length field in characters.
REQ-004: clk  input  1  single clock for all logic.
REQ-005: rst  input  1  asynchronous, active-high reset.
REQ-006: div_clk_en  input  N_CH  per-channel 16x-baud enable pulse, one clk wide.
REQ-007: rx_valid  input  N_CH  per-channel pulse: character written into RX FIFO.
REQ-008: rhr_valid  input  N_CH  per-channel level: RX FIFO not empty.
REQ-009: rd_rhr  input  N_CH  per-channel pulse: host read of RX holding register.
REQ-010: int_clr  input  N_CH  per-channel pulse: acknowledge timeout without reading data.
REQ-011: cfg_word_len  input  2*N_CH  per-channel data bits, 00=5, 01=6, 10=7, 11=8.
REQ-012: cfg_stop_bit  input  N_CH  per-channel, 1 adds one stop bit.
REQ-013: cfg_parity_en  input  N_CH  per-channel, 1 adds one parity bit.
REQ-014: cfg_fifo_enable  input  N_CH  per-channel FIFO mode enable.
REQ-015: cfg_to_chars  input  TO_W*N_CH  per-channel timeout length in character times; 0 disables the channel.
REQ-016: int_rx_timeout  output  N_CH  per-channel registered timeout interrupt level.
REQ-017: int_any  output  1  registered OR of all int_rx_timeout bits.

Function
REQ-018: Channels SHALL be fully independent; channel i uses bit/field i of every vector port.
REQ-019: frame_len SHALL be 2 + data_bits + cfg_stop_bit + cfg_parity_en (range 7..12).
REQ-020: Load value SHALL be cfg_to_chars * frame_len * 16, computed at CNT_W bits without truncation (max 7*12*16 = 1344).
REQ-021: Per-channel state machine states: IDLE, COUNT, EXPIRED, ACKED.
REQ-022: Channel is "armed" when cfg_fifo_enable=1, rhr_valid=1 and cfg_to_chars!=0.
REQ-023: Not armed in any state -> next state IDLE, counter = load value, interrupt deasserted; this condition has highest priority.
REQ-024: IDLE and armed -> COUNT with counter loaded.
REQ-025: COUNT, armed, rx_valid or rd_rhr -> stay COUNT, counter reloaded; reload beats decrement in the same cycle.
REQ-026: COUNT, div_clk_en, counter > 1 -> decrement by 1.
REQ-027: COUNT, div_clk_en, counter == 1, no rx_valid/rd_rhr -> EXPIRED, counter 0.
REQ-028: int_rx_timeout[i] SHALL be 1 exactly while channel i is in EXPIRED, asserting on the clk edge that enters EXPIRED.
REQ-029: EXPIRED, rx_valid or rd_rhr -> COUNT with reload (interrupt drops next edge).
REQ-030: EXPIRED, int_clr without rx_valid/rd_rhr -> ACKED; counter holds 0.
REQ-031: ACKED, rx_valid or rd_rhr -> COUNT with reload; otherwise stays ACKED with no interrupt.
REQ-032: int_clr outside EXPIRED SHALL have no effect.
REQ-033: Config changes while in COUNT SHALL take effect only at the next load; the running count is not rescaled.
REQ-034: int_any SHALL be the OR of the next-state interrupt bits, so it switches on the same edge as int_rx_timeout.

Reset
REQ-035: While rst=1, every channel is in IDLE, counters = 0, int_rx_timeout = 0, int_any = 0.
REQ-036: Reset assertion mid-count SHALL clear the state immediately; after release, a channel re-enters COUNT on the first armed cycle with a fresh load.

Verification
REQ-037: Ch0 8N1, cfg_to_chars=4, FIFO on, one rx_valid, rhr_valid held -> int_rx_timeout[0] rises on the edge of the 640th div_clk_en pulse and int_any rises on the same edge.
REQ-038: Ch1 5 data bits, parity, 2 stop bits, cfg_to_chars=7 -> timeout after 1008 pulses; rd_rhr at pulse 1000 with rhr_valid still 1 -> no interrupt until 1008 pulses after the rd_rhr.
REQ-039: Ch2 expired, rhr_valid drops -> interrupt clears next edge and the channel is in IDLE; a new rx_valid with rhr_valid=1 restarts the full count.
REQ-040: Ch3 expired, int_clr -> interrupt drops and stays low indefinitely; a later rx_valid -> re-expires after the full load value.
REQ-041: cfg_to_chars=0 or cfg_fifo_enable=0 on any channel with traffic -> that interrupt never asserts; other channels are unaffected.
REQ-042: rx_valid coincident with the final div_clk_en (counter == 1) -> no interrupt and the counter is reloaded; rst pulse mid-count -> all outputs 0 immediately.
